// File: rtl/icg_enable_ctrl.sv
// Enable controller for a latch+AND clock gate: wakes on request, acks after WAKE_CYC, closes after IDLE_CYC quiet cycles.
// Latency: E rises the edge after a wake is sampled, ACK WAKE_CYC edges later; no backpressure, REQ is a level held until ACK.
module icg_enable_ctrl #(
   parameter int NREQ     = 4,
   parameter int WAKE_CYC = 2,
   parameter int IDLE_CYC = 8,
   parameter int CW       = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NREQ-1:0] REQ,
   input  logic            BUSY,
   input  logic            FORCE,
   input  logic            CLR,
   output logic            E,
   output logic            ACK,
   output logic [1:0]      STATE,
   output logic [CW-1:0]   OFFCNT
);

   localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
   localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
   localparam logic [WW-1:0] W_LAST = WW'(WAKE_CYC - 1);
   localparam logic [IW-1:0] I_LAST = IW'(IDLE_CYC - 1);

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_WAKE = 2'd1,
      S_ON   = 2'd2,
      S_IDLE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic [IW-1:0]   icnt_q, icnt_d;
   logic [CW-1:0]   offcnt_q, offcnt_d;
   logic            e_q, ack_q;
   logic            wake, quiet;

   assign wake  = (|REQ) | FORCE;
   assign quiet = ~wake & ~BUSY;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      icnt_d  = icnt_q;
      case (state_q)
         S_OFF: begin
            if (wake) begin
               state_d = S_WAKE;
               wcnt_d  = '0;
            end
         end
         // wake phase always runs to completion, even if the request drops
         S_WAKE: begin
            if (wcnt_q == W_LAST) state_d = S_ON;
            else                  wcnt_d  = wcnt_q + 1'b1;
         end
         S_ON: begin
            if (quiet) begin
               state_d = S_IDLE;
               icnt_d  = '0;
            end
         end
         S_IDLE: begin
            if (!quiet) begin
               state_d = S_ON;
               icnt_d  = '0;
            end else if (icnt_q == I_LAST) begin
               state_d = S_OFF;
            end else begin
               icnt_d = icnt_q + 1'b1;
            end
         end
         default: state_d = S_OFF;
      endcase
   end

   always_comb begin
      offcnt_d = offcnt_q;
      if (CLR)
         offcnt_d = '0;
      else if (state_q == S_OFF && !(&offcnt_q))
         offcnt_d = offcnt_q + 1'b1;
   end

   // E/ACK registered from the next state so the ICG sees a clean flop output
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_OFF;
         wcnt_q   <= '0;
         icnt_q   <= '0;
         offcnt_q <= '0;
         e_q      <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         icnt_q   <= icnt_d;
         offcnt_q <= offcnt_d;
         e_q      <= (state_d != S_OFF);
         ack_q    <= (state_d == S_ON) || (state_d == S_IDLE);
      end
   end

   assign E      = e_q;
   assign ACK    = ack_q;
   assign STATE  = state_q;
   assign OFFCNT = offcnt_q;

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Bench for icg_enable_ctrl: cycle model feeds a scoreboard queue, plus directed latency checks.
module tb_icg_enable_ctrl;

   localparam int NREQ     = 4;
   localparam int WAKE_CYC = 2;
   localparam int IDLE_CYC = 8;
   localparam int CW       = 4;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic [NREQ-1:0] REQ = '0;
   logic            BUSY = 1'b0;
   logic            FORCE = 1'b0;
   logic            CLR = 1'b0;
   logic            E, ACK;
   logic [1:0]      STATE;
   logic [CW-1:0]   OFFCNT;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: 0 OFF, 1 WAKE, 2 ON, 3 IDLE; m_left = cycles remaining in WAKE/IDLE
   int m_state = 0;
   int m_left  = 0;
   int m_off   = 0;
   logic [7:0] exp_q[$];

   icg_enable_ctrl #(.NREQ(NREQ), .WAKE_CYC(WAKE_CYC), .IDLE_CYC(IDLE_CYC), .CW(CW)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .BUSY(BUSY), .FORCE(FORCE), .CLR(CLR),
      .E(E), .ACK(ACK), .STATE(STATE), .OFFCNT(OFFCNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst, input logic [NREQ-1:0] req,
                             input logic busy, input logic frc, input logic clr);
      logic w, q;
      int   was_off;
      w = (req != '0) || frc;
      q = !w && !busy;
      was_off = (m_state == 0);
      if (rst) begin
         m_state = 0; m_left = 0; m_off = 0;
      end else begin
         if (clr) m_off = 0;
         else if (was_off && m_off < (1 << CW) - 1) m_off = m_off + 1;
         case (m_state)
            0: if (w) begin m_state = 1; m_left = WAKE_CYC - 1; end
            1: if (m_left == 0) m_state = 2; else m_left = m_left - 1;
            2: if (q) begin m_state = 3; m_left = IDLE_CYC - 1; end
            default: begin
               if (!q) m_state = 2;
               else if (m_left == 0) m_state = 0;
               else m_left = m_left - 1;
            end
         endcase
      end
   endtask

   // called at a falling edge: drive, predict, clock, then compare at the next falling edge
   task automatic step(input logic rst, input logic [NREQ-1:0] req,
                       input logic busy, input logic frc, input logic clr);
      logic [7:0] e;
      RST = rst; REQ = req; BUSY = busy; FORCE = frc; CLR = clr;
      model_step(rst, req, busy, frc, clr);
      exp_q.push_back({2'(m_state), m_state != 0, m_state >= 2, 4'(m_off)});
      @(posedge CLK);
      @(negedge CLK);
      e = exp_q.pop_front();
      chk("sb_state",  32'(STATE),  32'(e[7:6]));
      chk("sb_e",      32'(E),      32'(e[5]));
      chk("sb_ack",    32'(ACK),    32'(e[4]));
      chk("sb_offcnt", 32'(OFFCNT), 32'(e[3:0]));
   endtask

   task automatic quiet_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wake_to_on();
      for (int i = 0; i < WAKE_CYC + 1; i++) step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      @(negedge CLK);
      // reset with a request pending
      step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
      chk("rst_e", 32'(E), 0);
      chk("rst_ack", 32'(ACK), 0);
      chk("rst_state", 32'(STATE), 0);
      chk("rst_offcnt", 32'(OFFCNT), 0);
      step(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
      chk("rst_exit_state", 32'(STATE), 1);
      quiet_n(2 + IDLE_CYC + 2);
      chk("back_off", 32'(STATE), 0);

      // wake latency
      step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("wake_e", 32'(E), 1);
      chk("wake_ack0", 32'(ACK), 0);
      step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("wake_ack1", 32'(ACK), 0);
      step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("wake_ack2", 32'(ACK), 1);
      chk("wake_on", 32'(STATE), 2);
      step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);

      // idle shutdown after exactly IDLE_CYC quiet cycles in IDLE
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("idle_enter", 32'(STATE), 3);
      quiet_n(IDLE_CYC - 1);
      chk("idle_hold_e", 32'(E), 1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("idle_off_state", 32'(STATE), 0);
      chk("idle_off_e", 32'(E), 0);
      chk("idle_off_ack", 32'(ACK), 0);

      // hysteresis restart on a BUSY pulse
      wake_to_on();
      quiet_n(5);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("busy_on", 32'(STATE), 2);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("busy_reidle", 32'(STATE), 3);
      quiet_n(IDLE_CYC - 1);
      chk("busy_hold", 32'(E), 1);
      quiet_n(1);
      chk("busy_off", 32'(E), 0);

      // BUSY alone never wakes from OFF
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("busy_nowake", 32'(STATE), 0);

      // single-cycle request still completes the wake
      step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
      quiet_n(WAKE_CYC);
      chk("noabort_ack", 32'(ACK), 1);
      quiet_n(1);
      chk("noabort_idle", 32'(STATE), 3);
      quiet_n(IDLE_CYC);
      chk("noabort_off", 32'(STATE), 0);

      // wake on the terminal IDLE cycle wins
      wake_to_on();
      quiet_n(IDLE_CYC);
      step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
      chk("term_wake_state", 32'(STATE), 2);
      chk("term_wake_e", 32'(E), 1);

      // FORCE holds the gate open
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("force_on", 32'(STATE), 2);

      // mid-operation reset drops E and ACK at that edge
      step(1'b1, '0, 1'b0, 1'b1, 1'b0);
      chk("midrst_e", 32'(E), 0);
      chk("midrst_ack", 32'(ACK), 0);

      // OFFCNT saturation and clear
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      quiet_n(20);
      chk("offcnt_sat", 32'(OFFCNT), 15);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("offcnt_clr", 32'(OFFCNT), 0);
      quiet_n(1);
      chk("offcnt_restart", 32'(OFFCNT), 1);

      // randomized traffic checked by the model only
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 40) == 0, 4'($urandom_range(0, 15) & {4{$urandom_range(0, 3) == 0}}),
              $urandom_range(0, 5) == 0, $urandom_range(0, 30) == 0, $urandom_range(0, 25) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
